// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - 24h packed-BCD hh:mm:ss timekeeper; time-load port compiled only with BCD_TIME_SET_EN
module bcd_timekeeper #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] Hours,
  output logic [7:0] Minutes,
  output logic [7:0] Seconds,
  output logic       tick_1hz,
  output logic       min_tick
`ifdef BCD_TIME_SET_EN
  ,
  input  logic       set_valid,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_seconds,
  output logic       set_ack,
  output logic       set_err
`endif
);

  // Prescaler counts 0..CLK_HZ-1; keep at least one bit so CLK_HZ=1 still elaborates.
  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  // Next packed-BCD value of a field; wraps to 00 at max_v. Callers only
  // ever hold legal BCD here, so the units==9 path never sees a tens overflow.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hours_q, hours_d;
  logic [7:0]    minutes_q, minutes_d;
  logic [7:0]    seconds_q, seconds_d;
  logic          tick_q, tick_d;
  logic          min_tick_q, min_tick_d;

  logic          presc_tc;
  logic          advance;
  logic          sec_wrap;
  logic          min_wrap;

  // Load request as seen by the counter path; tied off when the load port is absent.
  logic          load_ok;
  logic [7:0]    ld_hours;
  logic [7:0]    ld_minutes;
  logic [7:0]    ld_seconds;

  assign presc_tc = (presc_q == PRESC_TC);
  assign advance  = en && presc_tc;
  assign sec_wrap = (seconds_q == 8'h59);
  assign min_wrap = (minutes_q == 8'h59);

`ifdef BCD_TIME_SET_EN
  logic load_bad;
  logic set_ack_q, set_ack_d;
  logic set_err_q, set_err_d;

  // A field is legal when both nibbles are decimal and the tens digit is in range.
  function automatic logic bcd_field_ok(input logic [7:0] v, input logic [3:0] max_tens);
    return (v[3:0] <= 4'd9) && (v[7:4] <= max_tens);
  endfunction

  logic set_fields_ok;
  assign set_fields_ok = bcd_field_ok(set_hours, 4'd2) && (set_hours <= 8'h23) &&
                         bcd_field_ok(set_minutes, 4'd5) &&
                         bcd_field_ok(set_seconds, 4'd5);
  assign load_ok    = set_valid && set_fields_ok;
  assign load_bad   = set_valid && !set_fields_ok;
  assign ld_hours   = set_hours;
  assign ld_minutes = set_minutes;
  assign ld_seconds = set_seconds;

  // Load handshake pulses: one ack or one err per set_valid cycle.
  always_comb begin
    set_ack_d = load_ok;
    set_err_d = load_bad;
  end

  // Handshake pulse registers; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_ack_q <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      set_ack_q <= set_ack_d;
      set_err_q <= set_err_d;
    end
  end

  assign set_ack = set_ack_q;
  assign set_err = set_err_q;
`else
  assign load_ok    = 1'b0;
  assign ld_hours   = 8'h00;
  assign ld_minutes = 8'h00;
  assign ld_seconds = 8'h00;
`endif

  // Next time/prescaler: a valid load overrides (and swallows) any advance
  // in the same cycle; otherwise seconds carry into minutes into hours in one edge.
  always_comb begin
    presc_d    = presc_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    tick_d     = 1'b0;
    min_tick_d = 1'b0;
    if (load_ok) begin
      presc_d   = '0;
      hours_d   = ld_hours;
      minutes_d = ld_minutes;
      seconds_d = ld_seconds;
    end else begin
      if (en) begin
        presc_d = presc_tc ? '0 : presc_q + 1'b1;
      end
      if (advance) begin
        seconds_d = bcd_next(seconds_q, 8'h59);
        tick_d    = 1'b1;
        if (sec_wrap) begin
          minutes_d  = bcd_next(minutes_q, 8'h59);
          min_tick_d = 1'b1;
          if (min_wrap) begin
            hours_d = bcd_next(hours_q, 8'h23);
          end
        end
      end
    end
  end

  // Time, prescaler and pulse registers; reset discards any partial second.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      hours_q    <= 8'h00;
      minutes_q  <= 8'h00;
      seconds_q  <= 8'h00;
      tick_q     <= 1'b0;
      min_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      tick_q     <= tick_d;
      min_tick_q <= min_tick_d;
    end
  end

  assign Hours    = hours_q;
  assign Minutes  = minutes_q;
  assign Seconds  = seconds_q;
  assign tick_1hz = tick_q;
  assign min_tick = min_tick_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - self-checking bench for bcd_timekeeper (CLK_HZ=4), load tests under BCD_TIME_SET_EN
module tb_bcd_timekeeper;

  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hours = 8'h00;
  logic [7:0] set_minutes = 8'h00;
  logic [7:0] set_seconds = 8'h00;
  logic [7:0] Hours, Minutes, Seconds;
  logic       tick_1hz, min_tick;
  logic       ack_w, err_w;

  bcd_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .Hours(Hours),
    .Minutes(Minutes),
    .Seconds(Seconds),
    .tick_1hz(tick_1hz),
    .min_tick(min_tick)
`ifdef BCD_TIME_SET_EN
    ,
    .set_valid(set_valid),
    .set_hours(set_hours),
    .set_minutes(set_minutes),
    .set_seconds(set_seconds),
    .set_ack(ack_w),
    .set_err(err_w)
`endif
  );

`ifndef BCD_TIME_SET_EN
  assign ack_w = 1'b0;
  assign err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] h, m, s;
    logic       tick, mt, ack, err;
    int         tag;
  } exp_t;

  typedef struct {
    logic r, e;
    exp_t ex;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   m_tsec = 0;
  int   m_presc = 0;

  function automatic exp_t mk(input logic [7:0] h, m, s, input logic t, mt, a, er);
    exp_t x;
    x.h = h; x.m = m; x.s = s;
    x.tick = t; x.mt = mt; x.ack = a; x.err = er;
    x.tag = 0;
    return x;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int dec(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Behavioural model: time kept as a plain seconds-of-day integer.
  task automatic model_step(output exp_t ex);
    int h, mi, s;
    ex = mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    h  = dec(set_hours);
    mi = dec(set_minutes);
    s  = dec(set_seconds);
    if (rst) begin
      m_tsec  = 0;
      m_presc = 0;
    end else if (set_valid && h >= 0 && h < 24 && mi >= 0 && mi < 60 && s >= 0 && s < 60) begin
      m_tsec  = h * 3600 + mi * 60 + s;
      m_presc = 0;
      ex.ack  = 1'b1;
    end else begin
      if (set_valid) ex.err = 1'b1;
      if (en) begin
        if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          m_tsec  = (m_tsec + 1) % 86400;
          ex.tick = 1'b1;
          ex.mt   = (m_tsec % 60 == 0);
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
    ex.h = to_bcd(m_tsec / 3600);
    ex.m = to_bcd((m_tsec / 60) % 60);
    ex.s = to_bcd(m_tsec % 60);
  endtask

  task automatic check(input exp_t ex);
    n_total++;
    if ({Hours, Minutes, Seconds, tick_1hz, min_tick, ack_w, err_w} ===
        {ex.h, ex.m, ex.s, ex.tick, ex.mt, ex.ack, ex.err}) begin
      n_pass++;
    end else begin
      $display("FAIL chk%0d: got %h:%h:%h tick=%b min=%b ack=%b err=%b, expected %h:%h:%h tick=%b min=%b ack=%b err=%b",
               ex.tag, Hours, Minutes, Seconds, tick_1hz, min_tick, ack_w, err_w,
               ex.h, ex.m, ex.s, ex.tick, ex.mt, ex.ack, ex.err);
    end
  endtask

  // One clock: drive at negedge, push expectation, compare 1 time unit after posedge.
  task automatic cyc(input logic r, e, sv, input logic [7:0] sh, sm, ss,
                     input logic use_fixed, input exp_t fixed);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; set_valid = sv;
    set_hours = sh; set_minutes = sm; set_seconds = ss;
    model_step(ex);
    if (use_fixed) ex = fixed;
    ex.tag = n_total;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    check(sb_q.pop_front());
  endtask

  task automatic run(input logic r, e);
    cyc(r, e, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic ld(input logic e, input logic [7:0] sh, sm, ss);
    cyc(1'b0, e, 1'b1, sh, sm, ss, 1'b0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic add(input logic r, e, input logic [7:0] s, input logic t);
    vec_t v;
    v.r  = r;
    v.e  = e;
    v.ex = mk(8'h00, 8'h00, s, t, 1'b0, 1'b0, 1'b0);
    tbl.push_back(v);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;

    // Reset, first seconds, en freeze mid-second, reset mid-count, en low at terminal count.
    add(1, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h00, 0);
    add(0, 1, 8'h01, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h01, 0);
    add(0, 1, 8'h02, 1);
    add(0, 1, 8'h02, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 8'h02, 0);
    add(0, 1, 8'h02, 0);
    add(0, 1, 8'h02, 0);
    add(0, 1, 8'h03, 1);
    add(0, 1, 8'h03, 0);
    add(0, 1, 8'h03, 0);
    add(1, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h00, 0);
    add(0, 1, 8'h01, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h01, 0);
    add(0, 0, 8'h01, 0);
    add(0, 1, 8'h02, 1);
    add(0, 0, 8'h02, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, tbl[i].ex);
    end

    // Long run with random enable through several minute carries into hour 01.
    run(1'b1, 1'b0);
    budget = 0;
    while (m_tsec < 3605 && budget < 30000) begin
      run(1'b0, $urandom_range(0, 7) != 0);
      budget++;
    end
    n_total++;
    if (m_tsec >= 3605) n_pass++;
    else $display("FAIL long_run_budget: reached %0d s, required 3605 s", m_tsec);

`ifdef BCD_TIME_SET_EN
    // Load 00:00:59 then advance into minute 01.
    run(1'b1, 1'b1);
    cyc(0, 1, 1, 8'h00, 8'h00, 8'h59, 1, mk(8'h00, 8'h00, 8'h59, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) run(1'b0, 1'b1);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, mk(8'h00, 8'h01, 8'h00, 1, 1, 0, 0));

    // Load 23:59:59 then day rollover in one edge.
    cyc(0, 1, 1, 8'h23, 8'h59, 8'h59, 1, mk(8'h23, 8'h59, 8'h59, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) run(1'b0, 1'b1);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, mk(8'h00, 8'h00, 8'h00, 1, 1, 0, 0));

    // Rejected loads leave time counting normally.
    ld(1'b1, 8'h12, 8'h6A, 8'h00);
    ld(1'b1, 8'h00, 8'h00, 8'h5A);
    ld(1'b1, 8'h24, 8'h00, 8'h00);
    ld(1'b1, 8'h1A, 8'h00, 8'h00);
    ld(1'b1, 8'h00, 8'h60, 8'h00);
    run(1'b0, 1'b1);

    // Loads accepted with en low; held set_valid gives one response per cycle.
    cyc(0, 0, 1, 8'h01, 8'h02, 8'h03, 1, mk(8'h01, 8'h02, 8'h03, 0, 0, 1, 0));
    ld(1'b0, 8'h04, 8'h05, 8'h06);
    ld(1'b0, 8'h2F, 8'h00, 8'h00);
    ld(1'b1, 8'h07, 8'h08, 8'h09);
    for (int i = 0; i < 5; i++) run(1'b0, 1'b1);

    // Reset beats a simultaneous load.
    cyc(1, 1, 1, 8'h12, 8'h34, 8'h56, 1, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

    // Load coincident with terminal count discards that advance.
    for (int i = 0; i < 3; i++) run(1'b0, 1'b1);
    cyc(0, 1, 1, 8'h12, 8'h34, 8'h56, 1, mk(8'h12, 8'h34, 8'h56, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, mk(8'h12, 8'h34, 8'h56, 0, 0, 0, 0));
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, mk(8'h12, 8'h34, 8'h57, 1, 0, 0, 0));

    // Rejected load at terminal count: advance still happens alongside set_err.
    for (int i = 0; i < 3; i++) run(1'b0, 1'b1);
    ld(1'b1, 8'h99, 8'h00, 8'h00);
    run(1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter: CLK_HZ, 50000000, input clock frequency in Hz; prescaler terminal count is CLK_HZ-1.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: en  input  1  run enable; low freezes prescaler and time.
REQ-005 SHALL have port: Hours  output  8  packed BCD hours {tens,units}, 00-23.
REQ-006 SHALL have port: Minutes  output  8  packed BCD minutes {tens,units}, 00-59; feeds alarm stage.
REQ-007 SHALL have port: Seconds  output  8  packed BCD seconds {tens,units}, 00-59; feeds alarm stage.
REQ-008 SHALL have port: tick_1hz  output  1  one-cycle pulse on every seconds advance.
REQ-009 SHALL have port: min_tick  output  1  one-cycle pulse when Minutes changes by rollover (59->00 seconds).
REQ-010 SHALL have ports (TIME_SET_EN only): set_valid input 1 load request; set_hours/set_minutes/set_seconds input 8 each, packed BCD load values; set_ack output 1 load accepted pulse; set_err output 1 load rejected pulse.

Function
REQ-011 SHALL run a prescaler 0..CLK_HZ-1 while en=1; at terminal count it wraps to 0 next cycle.
REQ-012 SHALL advance Seconds on the edge where prescaler is at terminal count and en=1; tick_1hz high the following cycle only.
REQ-013 SHALL count seconds units 0-9 and tens 0-5; 59 -> 00 carries into Minutes in the same edge.
REQ-014 SHALL count minutes identically; 59:59 -> 00:00 carries into Hours in the same edge.
REQ-015 SHALL count hours 00-23; 23:59:59 -> 00:00:00 in one edge, no intermediate value visible.
REQ-016 SHALL assert min_tick in the same cycle as tick_1hz when the advance carried into Minutes.
REQ-017 SHALL keep all outputs registered; Hours/Minutes/Seconds change only on an advance or a load, never glitch between BCD digits.
REQ-018 SHALL never output a non-BCD nibble or out-of-range value in any cycle.
REQ-019 SHALL hold prescaler, time and pulses (pulses low) while en=0; resuming continues from held prescaler value.
REQ-020 SHALL (TIME_SET_EN) validate set inputs in the set_valid cycle: every nibble <=9, minutes/seconds tens <=5, hours <=0x23.
REQ-021 SHALL (TIME_SET_EN) on valid load: outputs take set values next cycle, prescaler cleared to 0, set_ack high one cycle, tick_1hz/min_tick low.
REQ-022 SHALL (TIME_SET_EN) on invalid load: time and prescaler unchanged (normal counting continues), set_err high one cycle.
REQ-023 SHALL (TIME_SET_EN) give valid load priority over a simultaneous terminal-count advance; that advance is discarded.
REQ-024 SHALL (TIME_SET_EN) accept loads regardless of en; set_valid held high reloads every cycle with one ack/err per cycle.

Reset
REQ-025 SHALL on rst=1 at a clock edge set Hours=00, Minutes=00, Seconds=00, prescaler=0, tick_1hz=0, min_tick=0, set_ack=0, set_err=0.
REQ-026 SHALL give rst priority over en, advance and load; reset mid-count discards the partial second.

Configuration
REQ-027 SHALL compile the load interface (REQ-010, REQ-020 to REQ-024) only when macro BCD_TIME_SET_EN is defined.
REQ-028 SHALL without BCD_TIME_SET_EN omit set_* ports entirely; time starts only from reset value 00:00:00 and only counts.

Verification (CLK_HZ=4 in bench)
REQ-029 SHALL cover: rst 1 cycle, en=1 -> Seconds=0x01 and tick_1hz pulse after 4 cycles, repeating every 4 cycles.
REQ-030 SHALL cover: load 00:00:59 then advance -> Minutes=0x01, Seconds=0x00, tick_1hz and min_tick high same cycle.
REQ-031 SHALL cover: load 23:59:59 then advance -> 00:00:00 in one cycle, min_tick=1.
REQ-032 SHALL cover: set_valid with set_minutes=0x6A -> set_err pulse, time unchanged; set_seconds=0x5A also rejected.
REQ-033 SHALL cover: set_valid coincident with terminal count, set 12:34:56 -> outputs 12:34:56 next cycle, no tick_1hz, next advance 4 cycles later.
REQ-034 SHALL cover: en=0 for 10 cycles mid-second then rst asserted during count -> frozen outputs, then 00:00:00 and prescaler 0.
